uart_cmd_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/frame_timer.sv | 36 +++
 rtl/uart_cmd_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART command path: sync byte, frame length and
// the command-parser state encoding.
package uart_pkg;

  // First byte of every command frame.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // SYNC, ADDR, DATA, CHK.
  localparam int FRAME_LEN = 4;

  // Parser state encoding, kept as plain constants so older code that
  // compares against raw values keeps working.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_GOT_SYNC = 3'd1;
  localparam state_t ST_GOT_ADDR = 3'd2;
  localparam state_t ST_GOT_DATA = 3'd3;
  localparam state_t ST_COMMIT   = 3'd4;

  // Frame checksum: XOR of address and data bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] data);
    return addr ^ data;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timer: loadable up-counter with clear and enable, raising tc
// in the cycle it sits at TIMEOUT_CYCLES-1 while still enabled.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 100,
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic          tc
);

  logic [CW-1:0] count;

  // Count idle clocks; clear has priority so a fresh byte restarts the wait.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and simulation matches the netlist.
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Terminal count only while counting; a clear in the same cycle suppresses it.
  assign tc = enable && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame-level command parser behind the UART receiver. Collects
// SYNC/ADDR/DATA/CHK frames, writes DATA into a small register bank and
// pulses an error flag for bad checksum, bad address or inter-byte timeout.
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ       = 50000000,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REGS       = 4,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 100
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          rx_data,
  input  logic                           rx_ready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic                           wr_strobe,
  output logic [7:0]                     wr_addr,
  output logic                           err_chk,
  output logic                           err_addr,
  output logic                           err_timeout,
  output logic                           busy
);

  localparam int TCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Register count widened by one bit so NUM_REGS=256 still compares cleanly.
  localparam logic [DATA_WIDTH:0] NUM_REGS_W = (DATA_WIDTH + 1)'(NUM_REGS);
  localparam logic [DATA_WIDTH-1:0] SYNC_W = DATA_WIDTH'(SYNC_BYTE);

  state_t                         state;
  logic [DATA_WIDTH-1:0]          addr_q;
  logic [DATA_WIDTH-1:0]          data_q;
  logic [NUM_REGS*DATA_WIDTH-1:0] reg_q;
  logic                           timer_en;
  logic                           timer_clr;
  logic                           timer_tc;
  logic                           is_sync;
  logic                           chk_ok;
  logic                           addr_ok;

  // Timer runs only while a frame is partially received; any byte restarts it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    timer_en  = 1'b0;
    timer_clr = 1'b1;
    if (state == ST_GOT_SYNC || state == ST_GOT_ADDR || state == ST_GOT_DATA) begin
      timer_en  = 1'b1;
      timer_clr = rx_ready;
    end
  end

  assign is_sync = (rx_data == SYNC_W);
  assign chk_ok  = (rx_data == (addr_q ^ data_q));
  assign addr_ok = ({1'b0, addr_q} < NUM_REGS_W);

  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clr),
    .enable    (timer_en),
    .load      (1'b0),
    .load_value({TCW{1'b0}}),
    .tc        (timer_tc)
  );

  // Frame parser, register bank and registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register bank is reset explicitly because downstream logic
      // relies on a known all-zero configuration after reset.
      state       <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      reg_q       <= '0;
      wr_addr     <= '0;
      wr_strobe   <= 1'b0;
      err_chk     <= 1'b0;
      err_addr    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      wr_strobe   <= 1'b0;
      err_chk     <= 1'b0;
      err_addr    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_ready && is_sync) state <= ST_GOT_SYNC;
        end
        ST_GOT_SYNC: begin
          if (rx_ready) begin
            addr_q <= rx_data;
            state  <= ST_GOT_ADDR;
          end else if (timer_tc) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_GOT_ADDR: begin
          if (rx_ready) begin
            data_q <= rx_data;
            state  <= ST_GOT_DATA;
          end else if (timer_tc) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_GOT_DATA: begin
          if (rx_ready) begin
            if (!chk_ok) begin
              err_chk <= 1'b1;
              state   <= ST_IDLE;
            end else if (!addr_ok) begin
              err_addr <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              state <= ST_COMMIT;
            end
          end else if (timer_tc) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if ({1'b0, addr_q} == (DATA_WIDTH + 1)'(i)) begin
              reg_q[i*DATA_WIDTH +: DATA_WIDTH] <= data_q;
            end
          end
          wr_strobe <= 1'b1;
          wr_addr   <= 8'(addr_q);
          // A sync byte landing here starts the next frame immediately.
          state     <= (rx_ready && is_sync) ? ST_GOT_SYNC : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign reg_out = reg_q;
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: a frame-level reference model
// compared against the DUT every cycle, plus literal expectations for the
// directed scenarios.
module tb_uart_cmd_ctrl;
  import uart_pkg::*;

  localparam int DW   = 8;
  localparam int NR   = 4;
  localparam int TO   = 100;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   rx_data;
  logic            rx_ready;
  logic [NR*DW-1:0] reg_out;
  logic            wr_strobe;
  logic [7:0]      wr_addr;
  logic            err_chk;
  logic            err_addr;
  logic            err_timeout;
  logic            busy;

  int checks = 0;
  int errors = 0;

  uart_cmd_ctrl #(
    .CLK_FREQ      (50000000),
    .DATA_WIDTH    (DW),
    .NUM_REGS      (NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .reg_out    (reg_out),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .err_chk    (err_chk),
    .err_addr   (err_addr),
    .err_timeout(err_timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [7:0] fq[$];
  int         gap;
  logic [7:0] m_regs[NR];
  int         m_wr_addr;
  bit         m_strobe, m_chk, m_addr, m_to;
  bit         pend;
  int         p_addr;
  logic [7:0] p_data;
  bit         model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      fq.delete();
      gap = 0;
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_wr_addr = 0;
      {m_strobe, m_chk, m_addr, m_to} = 4'b0;
      pend = 1'b0;
      model_ok = 1'b1;
    end else begin
      {m_strobe, m_chk, m_addr, m_to} = 4'b0;
      if (pend) begin
        m_regs[p_addr] = p_data;
        m_wr_addr = p_addr;
        m_strobe = 1'b1;
        pend = 1'b0;
      end
      if (rx_ready) begin
        gap = 0;
        if (fq.size() == 0) begin
          if (rx_data == SYNC_BYTE) fq.push_back(rx_data);
        end else begin
          fq.push_back(rx_data);
          if (fq.size() == FRAME_LEN) begin
            if (fq[3] != (fq[1] ^ fq[2])) m_chk = 1'b1;
            else if (int'(fq[1]) >= NR) m_addr = 1'b1;
            else begin
              pend = 1'b1;
              p_addr = int'(fq[1]);
              p_data = fq[2];
            end
            fq.delete();
          end
        end
      end else if (fq.size() != 0) begin
        gap++;
        if (gap == TO) begin
          m_to = 1'b1;
          fq.delete();
          gap = 0;
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge once reset was seen.
  always @(negedge clk) begin
    if (model_ok) begin
      logic [NR*DW-1:0] exp_regs;
      for (int i = 0; i < NR; i++) exp_regs[i*DW +: DW] = m_regs[i];
      check("m_reg_out", 64'(reg_out), 64'(exp_regs));
      check("m_wr_strobe", 64'(wr_strobe), 64'(m_strobe));
      check("m_wr_addr", 64'(wr_addr), 64'(m_wr_addr));
      check("m_err_chk", 64'(err_chk), 64'(m_chk));
      check("m_err_addr", 64'(err_addr), 64'(m_addr));
      check("m_err_timeout", 64'(err_timeout), 64'(m_to));
      check("m_busy", 64'(busy), 64'(fq.size() != 0 || pend));
    end
  end

  // Pulse tallies used by the directed checks.
  int n_strobe = 0;
  int n_err = 0;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_strobe += int'(wr_strobe);
      n_err += int'(err_chk) + int'(err_addr) + int'(err_timeout);
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; drives one byte for exactly one clock.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(SYNC_BYTE);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base_s, base_e, n;
    reset = 1'b1;
    rx_ready = 1'b0;
    rx_data = '0;
    idle(3);
    check("reset_reg_out", 64'(reg_out), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_wr_addr", 64'(wr_addr), 64'h0);
    reset = 1'b0;
    idle(2);

    // Valid frame: write lands two clocks after the CHK strobe.
    send_frame(8'h02, 8'h3C, 8'h3E);
    check("valid_commit_busy", 64'(busy), 64'h1);
    check("valid_not_yet", 64'(wr_strobe), 64'h0);
    idle(1);
    check("valid_reg2", 64'(reg_out[23:16]), 64'h3C);
    check("valid_strobe", 64'(wr_strobe), 64'h1);
    check("valid_wr_addr", 64'(wr_addr), 64'h2);
    idle(1);
    check("valid_strobe_low", 64'(wr_strobe), 64'h0);
    check("valid_wr_addr_held", 64'(wr_addr), 64'h2);
    idle(2);

    // Bad checksum.
    send_frame(8'h01, 8'h55, 8'h00);
    check("badchk_pulse", 64'(err_chk), 64'h1);
    idle(1);
    check("badchk_pulse_low", 64'(err_chk), 64'h0);
    check("badchk_busy", 64'(busy), 64'h0);
    check("badchk_regs", 64'(reg_out), 64'h003C0000);
    idle(2);

    // Address out of range.
    send_frame(8'h07, 8'h11, 8'h16);
    check("badaddr_pulse", 64'(err_addr), 64'h1);
    idle(2);
    check("badaddr_regs", 64'(reg_out), 64'h003C0000);

    // Truncated frame: timeout TO clocks after the last byte.
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    n = 0;
    while (n < 3 * TO && err_timeout !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 64'(n), 64'(TO));
    idle(1);
    check("timeout_busy", 64'(busy), 64'h0);
    send_frame(8'h03, 8'hAA, 8'hA9);
    idle(2);
    check("after_timeout_reg3", 64'(reg_out[31:24]), 64'hAA);

    // Byte arriving in the very cycle the timeout would fire wins.
    base_e = n_err;
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    idle(TO - 1);
    send_byte(8'h55);
    send_byte(8'h54);
    idle(2);
    check("race_no_error", 64'(n_err - base_e), 64'h0);
    check("race_reg1", 64'(reg_out[15:8]), 64'h55);

    // Back-to-back frames with the next SYNC in the COMMIT cycle.
    base_s = n_strobe;
    send_frame(8'h00, 8'hFF, 8'hFF);
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    send_byte(8'h0F);
    send_byte(8'h0E);
    idle(3);
    check("b2b_strobes", 64'(n_strobe - base_s), 64'h2);
    check("b2b_regs", 64'(reg_out), 64'hAA3C0FFF);
    check("b2b_wr_addr", 64'(wr_addr), 64'h1);

    // Reset mid-frame, then the rest of the frame must be ignored.
    send_byte(SYNC_BYTE);
    send_byte(8'h02);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("midreset_regs", 64'(reg_out), 64'h0);
    check("midreset_busy", 64'(busy), 64'h0);
    base_s = n_strobe;
    base_e = n_err;
    send_byte(8'h3C);
    send_byte(8'h3E);
    idle(4);
    check("midreset_no_write", 64'(n_strobe - base_s), 64'h0);
    check("midreset_no_err", 64'(n_err - base_e), 64'h0);
    check("midreset_regs_after", 64'(reg_out), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
